// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile_sb register file slice.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;

  // Index width for a register count; never narrower than one bit.
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits for in-flight writes. Allocation (set) wins over
// retirement (clear) on the same index; flush drops every pending producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ZERO_REG = 1,
  localparam int AW       = calc_aw(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_idx1,
  input  logic [AW-1:0] rd_idx2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear first so a same-index set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy1 = busy_q[rd_idx1];
  assign busy2 = busy_q[rd_idx2];

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage integer register file with scoreboard, clear sweep and debug tap.
// Define REGFILE_BYPASS_EN to forward writeback data/busy to the read ports
// in the write cycle; without it writes become visible the next cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ZERO_REG = 1,
  localparam int AW       = calc_aw(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  output logic            ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writedata,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // One extra bit so the terminal index is compared without wrapping.
  localparam logic [AW:0] CLR_LAST = (AW+1)'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW:0]     clr_idx_q, clr_idx_d;
  logic            clr_we;
  logic            clear_go;
  logic            wr_en;
  logic            alloc_en;
  logic            busy1, busy2;
  logic [XLEN-1:0] regs [NREGS];

  function automatic logic is_zero(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // FSM state and sweep index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state: sweep every index once, then idle until a clear request.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // FSM outputs: traffic is accepted only while idle.
  always_comb begin
    ready    = (state_q == ST_IDLE);
    clr_we   = (state_q == ST_CLEAR);
    clear_go = (state_q == ST_IDLE) && clear_req;
  end

  assign wr_en    = ready && reg_write && !is_zero(rd);
  assign alloc_en = ready && alloc_valid;

  // Register array; left unreset on purpose since the sweep zeroes it and reads are gated until then.
  always_ff @(posedge clk) begin
    if (clr_we)     regs[clr_idx_q[AW-1:0]] <= '0;
    else if (wr_en) regs[rd] <= writedata;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .flush   (clear_go),
    .set_en  (alloc_en),
    .set_idx (alloc_rd),
    .clr_en  (ready && reg_write),
    .clr_idx (rd),
    .rd_idx1 (rs1),
    .rd_idx2 (rs2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

  // Read ports, busy taps and debug tap, all forced to zero during the sweep.
  always_comb begin
    readdata1 = '0;
    readdata2 = '0;
    rs1_busy  = 1'b0;
    rs2_busy  = 1'b0;
    dbg_data  = '0;
    if (ready) begin
      if (!is_zero(rs1))      readdata1 = regs[rs1];
      if (!is_zero(rs2))      readdata2 = regs[rs2];
      if (!is_zero(dbg_addr)) dbg_data  = regs[dbg_addr];
      rs1_busy = busy1;
      rs2_busy = busy2;
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes the zero register, so index 0 is never forwarded.
      if (wr_en && (rd == rs1)) begin
        readdata1 = writedata;
        rs1_busy  = alloc_en && (alloc_rd == rs1) && !is_zero(rs1);
      end
      if (wr_en && (rd == rs2)) begin
        readdata2 = writedata;
        rs2_busy  = alloc_en && (alloc_rd == rs2) && !is_zero(rs2);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters, ZERO_REG=1).
// The reference model tracks architectural contents, busy flags and the
// remaining sweep length; it also honours REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req;
  logic            ready;
  logic [AW-1:0]   rs1, rs2, alloc_rd, rd, dbg_addr;
  logic [XLEN-1:0] readdata1, readdata2, writedata, dbg_data;
  logic            rs1_busy, rs2_busy, alloc_valid, reg_write;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready;
  int              m_left;

  regfile_sb dut (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .ready       (ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .readdata1   (readdata1),
    .readdata2   (readdata2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .reg_write   (reg_write),
    .rd          (rd),
    .writedata   (writedata),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] idx);
    if (!m_ready || idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd == idx) return writedata;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] idx);
    if (!m_ready || idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd == idx) return alloc_valid && (alloc_rd == idx);
`endif
    return m_busy[idx];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = NREGS;
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
  endtask

  // Model update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      end
    end else if (clear_req) begin
      m_ready = 1'b0;
      m_left  = NREGS;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      if (reg_write && rd != 0) m_regs[rd] = writedata;
      if (reg_write) m_busy[rd] = 1'b0;
      if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".ready"}, {63'd0, ready}, {63'd0, m_ready});
    chk({tag, ".rd1"}, readdata1, exp_read(rs1));
    chk({tag, ".rd2"}, readdata2, exp_read(rs2));
    chk({tag, ".busy1"}, {63'd0, rs1_busy}, {63'd0, exp_busy(rs1)});
    chk({tag, ".busy2"}, {63'd0, rs2_busy}, {63'd0, exp_busy(rs2)});
    chk({tag, ".dbg"}, dbg_data, (!m_ready || dbg_addr == 0) ? '0 : m_regs[dbg_addr]);
  endtask

  // Count rising edges until ready, bounded; the count itself is checked.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!ready && n < 200) begin
      check_all(tag);
      tick();
      n++;
    end
    chk({tag, ".cycles"}, XLEN'(n), XLEN'(exp_cycles));
  endtask

  task automatic idle_inputs();
    clear_req   = 1'b0;
    alloc_valid = 1'b0;
    reg_write   = 1'b0;
    alloc_rd    = '0;
    rd          = '0;
    writedata   = '0;
  endtask

  initial begin
    logic [XLEN-1:0] d7;
    reset = 1'b1;
    idle_inputs();
    rs1 = '0; rs2 = '0; dbg_addr = '0;
    model_reset();

    // Reset held: everything gated to zero.
    @(negedge clk);
    @(negedge clk);
    rs1 = 5'd3; rs2 = 5'd17; dbg_addr = 5'd9;
    check_all("in_reset");

    // Release: sweep takes NREGS cycles, then every index reads zero.
    reset = 1'b0;
    wait_ready("sweep0", NREGS);
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i); dbg_addr = AW'(i);
      check_all("zeroed");
      chk("zeroed.rd1c", readdata1, '0);
    end

    // Plain write then read back.
    reg_write = 1'b1; rd = 5'd5; writedata = 64'hDEAD_BEEF_0000_0001; rs1 = 5'd5;
    check_all("wr5");
    tick();
    reg_write = 1'b0;
    check_all("rd5");
    chk("rd5.const", readdata1, 64'hDEAD_BEEF_0000_0001);

    // Zero register ignores writes and allocation.
    reg_write = 1'b1; rd = 5'd0; writedata = 64'h1234; alloc_valid = 1'b1; alloc_rd = 5'd0; rs1 = 5'd0;
    check_all("wr0");
    tick();
    idle_inputs();
    check_all("rd0");
    chk("rd0.data", readdata1, '0);
    chk("rd0.busy", {63'd0, rs1_busy}, '0);

    // Scoreboard: allocate, write+alloc same index (set wins), then retire.
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs2 = 5'd7;
    check_all("alloc7");
    tick();
    alloc_valid = 1'b0;
    check_all("busy7");
    chk("busy7.const", {63'd0, rs2_busy}, 64'd1);
    d7 = 64'h0707_0707_A5A5_5A5A;
    reg_write = 1'b1; rd = 5'd7; writedata = d7; alloc_valid = 1'b1; alloc_rd = 5'd7;
    check_all("wa7");
    tick();
    idle_inputs();
    check_all("still7");
    chk("still7.const", {63'd0, rs2_busy}, 64'd1);
    reg_write = 1'b1; rd = 5'd7; writedata = d7 + 64'd1;
    check_all("ret7");
    tick();
    idle_inputs();
    check_all("free7");
    chk("free7.busy", {63'd0, rs2_busy}, 64'd0);
    chk("free7.data", readdata2, d7 + 64'd1);

    // Randomized traffic, including occasional clear requests.
    for (int c = 0; c < 300; c++) begin
      rs1         = AW'($urandom_range(0, NREGS - 1));
      rs2         = ($urandom_range(0, 3) == 0) ? rs1 : AW'($urandom_range(0, NREGS - 1));
      dbg_addr    = AW'($urandom_range(0, NREGS - 1));
      reg_write   = ($urandom_range(0, 1) == 1);
      rd          = ($urandom_range(0, 2) == 0) ? rs1 : AW'($urandom_range(0, NREGS - 1));
      writedata   = {$urandom, $urandom};
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_rd    = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREGS - 1));
      clear_req   = ($urandom_range(0, 79) == 0);
      check_all("rand");
      tick();
    end
    idle_inputs();
    for (int n = 0; n < 40 && !m_ready; n++) begin
      check_all("drain");
      tick();
    end

    // Clear sweep on demand: writes and a second request during it are dropped.
    reg_write = 1'b1; rd = 5'd3; writedata = 64'h3333_0000_3333_0000;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick();
    idle_inputs();
    rs1 = 5'd3; rs2 = 5'd9;
    check_all("prefill");
    clear_req = 1'b1;
    check_all("clrreq");
    tick();
    clear_req = 1'b0;
    reg_write = 1'b1; rd = 5'd3; writedata = 64'h0BAD;
    for (int k = 0; k < 5; k++) begin
      check_all("sweep_wr");
      tick();
    end
    clear_req = 1'b1;
    check_all("sweep_req");
    tick();
    clear_req = 1'b0;
    wait_ready("sweep1", NREGS - 6);
    reg_write = 1'b0;
    check_all("after_clr");
    chk("after_clr.rd3", readdata1, '0);
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i);
      #1;
      chk("after_clr.busy", {63'd0, rs1_busy}, '0);
    end

    // Reset mid-sweep restarts from index 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    model_reset();
    check_all("mid_reset");
    tick();
    reset = 1'b0;
    wait_ready("sweep2", NREGS);

    // Still functional afterwards.
    reg_write = 1'b1; rd = 5'd12; writedata = 64'hC0FF_EE00_1200_0012; rs1 = 5'd12; dbg_addr = 5'd12;
    tick();
    idle_inputs();
    check_all("post");
    chk("post.dbg", dbg_data, 64'hC0FF_EE00_1200_0012);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
